// File: rtl/dbus_ram.sv
// dbus_ram: single-port, word-organised data RAM answering LSU DBus requests.
// Write data is lane-steered by addr[1:0]; read data is returned right-aligned.
module dbus_ram #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_rd_en,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wr_data,
    input  logic [3:0]  dbus_wr_strobe,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_wait,
    output logic        dbus_err
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   mem [DEPTH];

    logic          req, fault, in_range, bad_strobe, finish;
    logic [1:0]    off;
    logic [4:0]    lanes;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, wr_word;

    assign req        = dbus_rd_en | dbus_wr_en;
    assign off        = dbus_addr[1:0];
    assign idx        = dbus_addr[AW+1:2];
    assign lanes      = {1'b0, dbus_wr_strobe} << off;
    // BASE_ADDR is aligned to the RAM size, so a tag compare is a full range check.
    assign in_range   = (dbus_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign bad_strobe = (dbus_wr_strobe != 4'h1) && (dbus_wr_strobe != 4'h3) &&
                        (dbus_wr_strobe != 4'hF);
    assign fault      = (dbus_rd_en & dbus_wr_en) | ~in_range |
                        (dbus_wr_en & (lanes[4] | bad_strobe));

    assign rd_word    = mem[idx] >> {off, 3'b000};
    assign wr_word    = dbus_wr_data << {off, 3'b000};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dbus_wait = 1'b0;
        dbus_err  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (fault) begin
                        dbus_err = 1'b1;
                    end else begin
                        dbus_wait = 1'b1;
                        // The accepting cycle is the mandatory stall; BUSY covers the extra ones.
                        if (WAIT_STATES == 0) begin
                            finish    = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt   = CNT_INIT;
                            state_nxt = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                dbus_wait = 1'b1;
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            dbus_wait = 1'b0;
            dbus_err  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            dbus_rd_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (finish && dbus_rd_en)
                dbus_rd_data <= rd_word;
        end
    end

    // Writes commit only on the closing edge of DONE, so aborts and resets never touch memory.
    always_ff @(posedge clk) begin
        if (state == DONE && dbus_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i])
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_ram.sv
// Bench for dbus_ram: vector table on a zero-wait instance, hand sequences on a 3-wait instance.
module tb_dbus_ram;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [3:0]  strobe;

    logic        rd0, wr0, rd1, wr1;
    logic [31:0] rdata0, rdata1;
    logic        wait0, wait1, err0, err1;
    logic        wait_m, err_m;
    logic [31:0] rdata_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rd0     = rd_en & ~sel;
    assign wr0     = wr_en & ~sel;
    assign rd1     = rd_en & sel;
    assign wr1     = wr_en & sel;
    assign wait_m  = sel ? wait1 : wait0;
    assign err_m   = sel ? err1 : err0;
    assign rdata_m = sel ? rdata1 : rdata0;

    dbus_ram #(.DEPTH(1024), .BASE_ADDR(32'h2000_0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(rd0), .dbus_wr_en(wr0),
        .dbus_addr(addr), .dbus_wr_data(wdata), .dbus_wr_strobe(strobe),
        .dbus_rd_data(rdata0), .dbus_wait(wait0), .dbus_err(err0)
    );

    dbus_ram #(.DEPTH(1024), .BASE_ADDR(32'h2000_0000), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(rd1), .dbus_wr_en(wr1),
        .dbus_addr(addr), .dbus_wr_data(wdata), .dbus_wr_strobe(strobe),
        .dbus_rd_data(rdata1), .dbus_wait(wait1), .dbus_err(err1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        logic        exp_err;
        int          exp_wc;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request and follows it to completion or fault; wc counts cycles with wait high.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output int wc, output logic e);
        int guard;
        bit done;
        wc = 0; e = 1'b0; done = 1'b0; guard = 0;
        rd_en = rd; wr_en = wr; addr = a; wdata = d; strobe = s;
        while (!done && guard < 40) begin
            @(negedge clk);
            if (err_m) begin
                e    = 1'b1;
                done = 1'b1;
                if (wait_m) wc = 99;
            end else if (wait_m) begin
                wc++;
            end else begin
                done = 1'b1;
            end
            guard++;
            @(posedge clk); #1;
        end
        rd_en = 1'b0; wr_en = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: addr %h still waiting after %0d cycles", a, guard);
        end
    endtask

    initial begin
        int   wc;
        logic e;
        string nm;

        vecs[0]  = '{1'b0, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b0, 1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h2000_0003, 32'h0000_00A5, 4'h1, 1'b0, 1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h2000_0003, 32'h0,         4'h1, 1'b0, 1, 32'h0000_00A5};
        vecs[4]  = '{1'b0, 1'b1, 32'h2000_0003, 32'h0000_BEEF, 4'h3, 1'b1, 0, 32'h0000_00A5};
        vecs[5]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b0, 1, 32'hA5AD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h2000_1000, 32'h0,         4'hF, 1'b1, 0, 32'hA5AD_BEEF};
        vecs[7]  = '{1'b1, 1'b1, 32'h2000_0000, 32'h1111_1111, 4'hF, 1'b1, 0, 32'hA5AD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 32'h1FFF_FFFC, 32'h0,         4'hF, 1'b1, 0, 32'hA5AD_BEEF};
        vecs[9]  = '{1'b0, 1'b1, 32'h2000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 1, 32'hA5AD_BEEF};
        vecs[10] = '{1'b1, 1'b0, 32'h2000_0FFC, 32'h0,         4'hF, 1'b0, 1, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 1'b1, 32'h2000_0002, 32'h0000_BEEF, 4'h3, 1'b0, 1, 32'hCAFE_F00D};
        vecs[12] = '{1'b1, 1'b0, 32'h2000_0002, 32'h0,         4'h3, 1'b0, 1, 32'h0000_BEEF};
        vecs[13] = '{1'b0, 1'b1, 32'h2000_0000, 32'h7777_7777, 4'h5, 1'b1, 0, 32'h0000_BEEF};
        vecs[14] = '{1'b1, 1'b0, 32'h2000_0001, 32'h0,         4'hF, 1'b0, 1, 32'h00BE_EFBE};
        vecs[15] = '{1'b0, 1'b1, 32'h2000_0001, 32'h0000_0011, 4'h1, 1'b0, 1, 32'h00BE_EFBE};
        vecs[16] = '{1'b0, 1'b1, 32'h2000_0000, 32'hFFFF_FF22, 4'h1, 1'b0, 1, 32'h00BE_EFBE};
        vecs[17] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b0, 1, 32'hBEEF_1122};
        vecs[18] = '{1'b0, 1'b1, 32'h2000_0001, 32'h5555_5555, 4'hF, 1'b1, 0, 32'hBEEF_1122};
        vecs[19] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b0, 1, 32'hBEEF_1122};

        rst_n = 1'b0; sel = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; strobe = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wait0", {31'd0, wait0}, 32'd0);
        check("reset_err0",  {31'd0, err0},  32'd0);
        check("reset_rd0",   rdata0, 32'd0);
        check("reset_rd1",   rdata1, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strobe, wc, e);
            nm = $sformatf("vec%0d_err", i);
            check(nm, {31'd0, e}, {31'd0, vecs[i].exp_err});
            nm = $sformatf("vec%0d_waitcycles", i);
            check(nm, wc, vecs[i].exp_wc);
            nm = $sformatf("vec%0d_rdata", i);
            check(nm, rdata0, vecs[i].exp_rd);
        end

        // Three wait states: full-latency write then read
        sel = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 1'b1, 32'h2000_0010, 32'h55AA_55AA, 4'hF, wc, e);
        check("ws3_sw_wait", wc, 4);
        run_txn(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, wc, e);
        check("ws3_lw_wait", wc, 4);
        check("ws3_lw_data", rdata1, 32'h55AA_55AA);
        run_txn(1'b0, 1'b1, 32'h2000_0014, 32'h1357_2468, 4'hF, wc, e);
        check("ws3_sw2_wait", wc, 4);

        // Read dropped in BUSY cycle 2
        rd_en = 1'b1; addr = 32'h2000_0014; strobe = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
        check("abort_rd_wait", {31'd0, wait1}, 32'd0);
        check("abort_rd_data", rdata1, 32'h55AA_55AA);
        repeat (4) @(posedge clk); #1;
        check("abort_rd_data_hold", rdata1, 32'h55AA_55AA);
        run_txn(1'b1, 1'b0, 32'h2000_0014, 32'h0, 4'hF, wc, e);
        check("after_abort_wait", wc, 4);
        check("after_abort_data", rdata1, 32'h1357_2468);

        // Write dropped in BUSY never commits
        wr_en = 1'b1; addr = 32'h2000_0010; wdata = 32'h9999_9999; strobe = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (3) @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, wc, e);
        check("abort_wr_data", rdata1, 32'h55AA_55AA);

        // Reset asserted while a write is in BUSY
        run_txn(1'b0, 1'b1, 32'h2000_0020, 32'hDEAD_BEEF, 4'hF, wc, e);
        check("rst_seed_wait", wc, 4);
        wr_en = 1'b1; addr = 32'h2000_0020; wdata = 32'h1234_5678; strobe = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wait", {31'd0, wait1}, 32'd0);
        check("rst_mid_err",  {31'd0, err1},  32'd0);
        check("rst_mid_rd",   rdata1, 32'd0);
        repeat (2) @(posedge clk); #1;
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 32'h2000_0020, 32'h0, 4'hF, wc, e);
        check("rst_after_wait", wc, 4);
        check("rst_after_data", rdata1, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit 200000", $time);
        $fatal(1, "timeout");
    end
endmodule
